// File: rtl/elc_call_scheduler.sv
// ---------------------------------------------------------------------------
// elc_call_scheduler
//   Request-side front end of the elevator controller. Floor call buttons are
//   edge-captured into a pending-call set, and a SCAN (sweep) policy picks the
//   next target floor. The target goes to the controller as a one-hot
//   request_floor and is held until the controller pulses complete. That call
//   is then cleared and the next one is chosen. When the car sits idle away
//   from HOME_FLOOR for IDLE_TIMEOUT cycles, a home call is inserted.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-high reset
//   call_btn       level call buttons (car + hall merged); a rising edge registers a call
//   cur_floor      one-hot current floor from the controller (lowest set bit wins)
//   complete       controller arrived at request_floor (1-cycle pulse)
//   over_weight    car overloaded; holds the scheduler in its selection cycle
//   request_floor  one-hot target floor, held stable while req_valid
//   req_valid      request_floor is valid
//   pending        outstanding call lamps
//   sweep_up       current sweep direction, 1 = up
//   busy           scheduler is not idle
// ---------------------------------------------------------------------------
module elc_call_scheduler #(
    parameter int NUM_FLOORS   = 8,
    parameter int HOME_FLOOR   = 0,
    parameter int IDLE_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] call_btn,
    input  logic [NUM_FLOORS-1:0] cur_floor,
    input  logic                  complete,
    input  logic                  over_weight,
    output logic [NUM_FLOORS-1:0] request_floor,
    output logic                  req_valid,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  sweep_up,
    output logic                  busy
);

    localparam int IW = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1;
    localparam int CW = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [NUM_FLOORS-1:0] ONE = NUM_FLOORS'(1);

    typedef enum logic [1:0] {IDLE, SELECT, DISPATCH} state_t;

    state_t                  state;
    logic [NUM_FLOORS-1:0]   btn_q;
    logic [CW-1:0]           idle_cnt;
    logic [IW-1:0]           tgt_idx;

    logic [IW-1:0]           cur_idx;
    logic [IW-1:0]           up_ge, up_gt, dn_le, dn_lt;
    logic                    up_ge_ok, dn_le_ok;
    logic [IW-1:0]           sel_idx;
    logic                    sel_flip;
    logic                    idle_run, home_fire;
    logic [NUM_FLOORS-1:0]   pend_nxt;

    // Current floor index: lowest set bit, all-zero decodes as floor 0.
    always_comb begin
        cur_idx = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--)
            if (cur_floor[i]) cur_idx = IW'(i);
    end

    // SCAN candidates. Descending loop leaves the lowest match, ascending
    // loop leaves the highest match.
    always_comb begin
        up_ge_ok = 1'b0;
        up_ge    = '0;
        up_gt    = '0;
        dn_le_ok = 1'b0;
        dn_le    = '0;
        dn_lt    = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && IW'(i) >= cur_idx) begin
                up_ge_ok = 1'b1;
                up_ge    = IW'(i);
            end
            if (pending[i] && IW'(i) > cur_idx)
                up_gt = IW'(i);
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i] && IW'(i) <= cur_idx) begin
                dn_le_ok = 1'b1;
                dn_le    = IW'(i);
            end
            if (pending[i] && IW'(i) < cur_idx)
                dn_lt = IW'(i);
        end
    end

    // When nothing remains ahead in the sweep direction, reverse. Selection
    // only happens with pending != 0, so the reverse candidate exists then.
    always_comb begin
        sel_idx  = '0;
        sel_flip = 1'b0;
        if (sweep_up) begin
            if (up_ge_ok) sel_idx = up_ge;
            else begin
                sel_idx  = dn_lt;
                sel_flip = 1'b1;
            end
        end else begin
            if (dn_le_ok) sel_idx = dn_le;
            else begin
                sel_idx  = up_gt;
                sel_flip = 1'b1;
            end
        end
    end

    assign idle_run  = (state == IDLE) && (pending == '0) && (cur_idx != IW'(HOME_FLOOR));
    assign home_fire = idle_run && (idle_cnt == CW'(IDLE_TIMEOUT - 1));

    // Next pending set. The completion clear comes after capture, so a fresh
    // press of the target floor on the complete cycle is dropped.
    always_comb begin
        pend_nxt = pending | (call_btn & ~btn_q);
        if (state == DISPATCH && complete) pend_nxt[tgt_idx] = 1'b0;
        if (home_fire) pend_nxt[HOME_FLOOR] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            btn_q         <= '0;
            pending       <= '0;
            idle_cnt      <= '0;
            tgt_idx       <= '0;
            request_floor <= '0;
            req_valid     <= 1'b0;
            sweep_up      <= 1'b1;
            busy          <= 1'b0;
        end else begin
            btn_q    <= call_btn;
            pending  <= pend_nxt;
            idle_cnt <= (idle_run && !home_fire) ? idle_cnt + CW'(1) : '0;
            case (state)
                IDLE: begin
                    if (pending != '0) begin
                        state <= SELECT;
                        busy  <= 1'b1;
                    end
                end
                SELECT: begin
                    // Overload freezes dispatch; capture keeps running.
                    if (!over_weight) begin
                        if (pending == '0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            tgt_idx       <= sel_idx;
                            request_floor <= ONE << sel_idx;
                            req_valid     <= 1'b1;
                            if (sel_flip) sweep_up <= ~sweep_up;
                            state         <= DISPATCH;
                        end
                    end
                end
                DISPATCH: begin
                    if (complete) begin
                        request_floor <= '0;
                        req_valid     <= 1'b0;
                        state         <= SELECT;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
